// File: rtl/cereal_tx.sv
// rtl/cereal_tx.sv - parametrised UART transmitter with per-frame baud counter
// Serialises one word per valid/ready handshake: start, data LSB first, optional parity, stop.
module cereal_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 cereal,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT * 2);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
      $error("cereal_tx: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 cereal_d, ready_d, busy_d, done_d;
  logic                 bit_end, stop_end;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      cereal  <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cereal  <= cereal_d;
      ready   <= ready_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    cereal_d = cereal;
    ready_d  = ready;
    busy_d   = busy;
    done_d   = 1'b0;
    bit_end  = (cnt_q == BIT_LAST);
    stop_end = (cnt_q == STOP_LAST);

    if (state_q != S_IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        cereal_d = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        if (valid && ready) begin
          // Parity is frozen from the accepted word so later bus activity cannot disturb it.
          shift_d  = data;
          par_d    = (PARITY == 1) ? ~^data : ^data;
          state_d  = S_START;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          cereal_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d    = '0;
          idx_d    = '0;
          state_d  = S_DATA;
          cereal_d = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            if (PARITY != 0) begin
              state_d  = S_PARITY;
              cereal_d = par_q;
            end else begin
              state_d  = S_STOP;
              cereal_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 1'b1;
            shift_d  = shift_q >> 1;
            cereal_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d    = '0;
          state_d  = S_STOP;
          cereal_d = 1'b1;
        end
      end
      S_STOP: begin
        // One counter run covers all stop bits, hence the doubled counter width.
        if (stop_end) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          cereal_d = 1'b1;
          ready_d  = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        cereal_d = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cereal_tx.sv
// tb/tb_cereal_tx.sv - self-checking bench for cereal_tx across five parameter sets
// A frame-level line model predicts the serial level for every cycle of each frame.
module tb_cereal_tx;

  localparam int N = 5;
  localparam int DB  [N] = '{8, 7, 7, 8, 8};
  localparam int PAR [N] = '{0, 2, 1, 0, 0};
  localparam int SB  [N] = '{1, 1, 1, 2, 1};
  localparam int CPB [N] = '{4, 4, 4, 4, 5208};

  logic       clk;
  logic       reset;
  logic [8:0] d   [N];
  logic       v   [N];
  logic       rdy [N];
  logic       ser [N];
  logic       bsy [N];
  logic       dn  [N];

  int vectors = 0;
  int errors  = 0;

  cereal_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .sysclk(clk), .reset(reset), .data(d[0][7:0]), .valid(v[0]),
    .ready(rdy[0]), .cereal(ser[0]), .busy(bsy[0]), .done(dn[0]));
  cereal_tx #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .sysclk(clk), .reset(reset), .data(d[1][6:0]), .valid(v[1]),
    .ready(rdy[1]), .cereal(ser[1]), .busy(bsy[1]), .done(dn[1]));
  cereal_tx #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
    .sysclk(clk), .reset(reset), .data(d[2][6:0]), .valid(v[2]),
    .ready(rdy[2]), .cereal(ser[2]), .busy(bsy[2]), .done(dn[2]));
  cereal_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .sysclk(clk), .reset(reset), .data(d[3][7:0]), .valid(v[3]),
    .ready(rdy[3]), .cereal(ser[3]), .busy(bsy[3]), .done(dn[3]));
  cereal_tx #(.CLKS_PER_BIT(5208), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_slow (
    .sysclk(clk), .reset(reset), .data(d[4][7:0]), .valid(v[4]),
    .ready(rdy[4]), .cereal(ser[4]), .busy(bsy[4]), .done(dn[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Wait (bounded) for ready, present the word, and return just after the accepting edge.
  task automatic send(input int i, input logic [8:0] w);
    int t;
    t = 0;
    @(negedge clk);
    while (!rdy[i] && t < 200000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_accept", rdy[i], 1'b1);
    d[i] = w;
    v[i] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain, 1: scramble data/valid during the frame, 2: leave valid high for chaining
  task automatic check_frame(input int i, input logic [8:0] w, input int mode);
    logic lv[$];
    int   ones, c, total;
    c    = CPB[i];
    ones = 0;
    lv.push_back(1'b0);
    for (int b = 0; b < DB[i]; b++) begin
      lv.push_back(w[b]);
      ones += int'(w[b]);
    end
    if (PAR[i] == 1) lv.push_back((ones % 2) == 0);
    if (PAR[i] == 2) lv.push_back((ones % 2) == 1);
    for (int s = 0; s < SB[i]; s++) lv.push_back(1'b1);
    total = lv.size() * c;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      chk("line", ser[i], lv[k / c]);
      chk("busy_in_frame", bsy[i], 1'b1);
      chk("ready_in_frame", rdy[i], 1'b0);
      chk("done_in_frame", dn[i], 1'b0);
      if (mode == 1) begin
        d[i] = 9'($urandom);
        v[i] = (k == total - 1) ? 1'b0 : 1'($urandom);
      end
    end
    @(negedge clk);
    chk("done_pulse", dn[i], 1'b1);
    chk("ready_at_done", rdy[i], 1'b1);
    chk("busy_at_done", bsy[i], 1'b0);
    chk("idle_line_at_done", ser[i], 1'b1);
    if (mode != 2) begin
      @(negedge clk);
      chk("done_single_cycle", dn[i], 1'b0);
      chk("no_second_accept", bsy[i], 1'b0);
    end
  endtask

  initial begin
    logic [8:0] w;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      d[i] = '0;
      v[i] = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("reset_cereal", ser[i], 1'b1);
      chk("reset_ready", rdy[i], 1'b1);
      chk("reset_busy", bsy[i], 1'b0);
      chk("reset_done", dn[i], 1'b0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    send(0, 9'h0A5);
    v[0] = 1'b0;
    check_frame(0, 9'h0A5, 0);
    for (int r = 0; r < 3; r++) begin
      w = 9'($urandom);
      send(0, w);
      v[0] = 1'b0;
      check_frame(0, w, 0);
    end

    for (int i = 1; i <= 2; i++) begin
      send(i, 9'h055);
      v[i] = 1'b0;
      check_frame(i, 9'h055, 0);
      for (int r = 0; r < 2; r++) begin
        w = 9'($urandom);
        send(i, w);
        v[i] = 1'b0;
        check_frame(i, w, 0);
      end
    end

    send(3, 9'h000);
    d[3] = 9'h0FF;
    check_frame(3, 9'h000, 2);
    @(posedge clk);
    #1;
    v[3] = 1'b0;
    check_frame(3, 9'h0FF, 0);

    w = 9'($urandom);
    send(0, w);
    check_frame(0, w, 1);

    w = 9'($urandom);
    send(0, w);
    v[0] = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      chk("line_before_reset", ser[0], (k < 4) ? 1'b0 : w[k / 4 - 1]);
    end
    reset = 1'b1;
    #1;
    chk("async_reset_cereal", ser[0], 1'b1);
    chk("async_reset_ready", rdy[0], 1'b1);
    chk("async_reset_busy", bsy[0], 1'b0);
    chk("async_reset_done", dn[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk("no_done_after_reset", dn[0], 1'b0);
      chk("idle_after_reset", ser[0], 1'b1);
    end
    send(0, 9'h03C);
    v[0] = 1'b0;
    check_frame(0, 9'h03C, 0);

    send(4, 9'h041);
    v[4] = 1'b0;
    check_frame(4, 9'h041, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
